data_mem_dumper: RTL and testbench

DATA_MEM_DUMPER -- requirements
Module: data_mem_dumper

---
 rtl/data_mem_dumper_pkg.sv | 8 +
 rtl/data_mem_dumper.sv | 89 ++++++++
 tb/tb_data_mem_dumper.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/data_mem_dumper_pkg.sv
// data_mem_dumper_pkg: shared data-memory widths and dumper state encoding.
package data_mem_dumper_pkg;
  localparam int BIP_ADDR_W = 11;
  localparam int BIP_DATA_W = 16;
  typedef enum logic [2:0] {
    IDLE, READ, CAPT, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, NEXT
  } dump_state_t;
endpackage

// File: rtl/data_mem_dumper.sv
// data_mem_dumper: streams data memory words 0..LAST_ADDR to a UART as high/low bytes.
module data_mem_dumper
  import data_mem_dumper_pkg::*;
#(
  parameter int ADDR_W = BIP_ADDR_W,
  parameter int DATA_W = BIP_DATA_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] LAST_ADDR,
  output logic              MEM_RD,
  output logic              MEM_WR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              TX_START,
  output logic [7:0]        TX_DATA,
  input  logic              TX_DONE,
  output logic              BUSY,
  output logic              DONE
);
  dump_state_t       state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last;
  logic [15:0]       word;
  assign MEM_WR = 1'b0;
  // Outputs are registered alongside the state so they are valid in the state they belong to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= '0;
      word     <= '0;
      MEM_RD   <= 1'b0;
      MEM_ADDR <= '0;
      TX_START <= 1'b0;
      TX_DATA  <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          last     <= LAST_ADDR;
          cnt      <= '0;
          MEM_RD   <= 1'b1;
          MEM_ADDR <= '0;
          BUSY     <= 1'b1;
          state    <= READ;
        end
        READ: begin
          MEM_RD <= 1'b0;
          state  <= CAPT;
        end
        CAPT: begin
          word     <= MEM_DATA[15:0];
          TX_START <= 1'b1;
          TX_DATA  <= MEM_DATA[15:8];
          state    <= SEND_HI;
        end
        SEND_HI: begin
          TX_START <= 1'b0;
          state    <= WAIT_HI;
        end
        WAIT_HI: if (TX_DONE) begin
          TX_START <= 1'b1;
          TX_DATA  <= word[7:0];
          state    <= SEND_LO;
        end
        SEND_LO: begin
          TX_START <= 1'b0;
          state    <= WAIT_LO;
        end
        WAIT_LO: if (TX_DONE) state <= NEXT;
        NEXT: if (cnt == last) begin
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= IDLE;
        end else begin
          cnt      <= cnt + 1'b1;
          MEM_RD   <= 1'b1;
          MEM_ADDR <= cnt + 1'b1;
          state    <= READ;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_dumper.sv
// tb_data_mem_dumper: directed checks of the memory dumper against a memory and UART model.
module tb_data_mem_dumper;
  logic        CLK = 0, RESET = 1, START = 0, TX_DONE;
  logic [10:0] LAST_ADDR = '0;
  logic        MEM_RD, MEM_WR, TX_START, BUSY, DONE;
  logic [10:0] MEM_ADDR;
  logic [15:0] MEM_DATA = '0;
  logic [7:0]  TX_DATA;
  logic [15:0] mem [0:2047];
  logic [7:0]  bytes_q [$];
  logic [10:0] rd_q [$];
  int vectors = 0, miscompares = 0;
  int done_cnt = 0, wr_seen = 0, cd = 0, tx_lat = 5;
  logic resp_done = 0, spur = 0, spur_en = 0, prev_rd = 0;

  data_mem_dumper dut (.CLK(CLK), .RESET(RESET), .START(START), .LAST_ADDR(LAST_ADDR),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .TX_START(TX_START), .TX_DATA(TX_DATA), .TX_DONE(TX_DONE), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;
  assign TX_DONE = resp_done | spur;

  always @(posedge CLK) if (MEM_RD) MEM_DATA <= mem[MEM_ADDR];

  // Observe outputs and answer each byte request after tx_lat cycles.
  always @(negedge CLK) begin
    resp_done = 0;
    if (TX_START) bytes_q.push_back(TX_DATA);
    if (MEM_RD) rd_q.push_back(MEM_ADDR);
    if (DONE) done_cnt++;
    if (MEM_WR) wr_seen++;
    if (cd > 0) begin
      cd--;
      if (cd == 0) resp_done = 1;
    end
    if (TX_START) cd = tx_lat;
    if (RESET) cd = 0;
    spur = spur_en && (MEM_RD || prev_rd);
    prev_rd = MEM_RD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic kick(input logic [10:0] la);
    START = 1; LAST_ADDR = la;
    cyc();
    START = 0;
  endtask

  task automatic clear_obs();
    bytes_q.delete(); rd_q.delete(); done_cnt = 0; wr_seen = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin cyc(); n++; end
    check({tag, "_timeout"}, 32'(n >= budget), 0);
    cyc(3);
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, MEM_RD, MEM_WR, MEM_ADDR, TX_START, TX_DATA, BUSY, DONE} & 32'h3ffff;
  endfunction

  initial begin
    int bad, zero_rd;
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 16'h0103 + 16'h5a);
    cyc(3);
    check("reset_outs", outs(), 0);
    RESET = 0;
    cyc(2);
    check("idle_busy", 32'(BUSY), 0);

    // Two-word dump, high byte first.
    mem[0] = 16'h1234; mem[1] = 16'habcd;
    clear_obs();
    kick(1);
    check("busy_after_start", 32'(BUSY), 1);
    check("rd_addr_first", 32'(MEM_ADDR), 0);
    wait_done("two_word", 200);
    check("two_word_nbytes", bytes_q.size(), 4);
    check("two_word_bytes", {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]}, 32'h1234abcd);
    check("two_word_done", done_cnt, 1);
    check("two_word_busy", 32'(BUSY), 0);
    check("two_word_reads", rd_q.size(), 2);
    check("two_word_addr1", 32'(rd_q[1]), 1);

    // Single word dump.
    mem[0] = 16'h00ff;
    clear_obs();
    kick(0);
    wait_done("one_word", 100);
    check("one_word_nbytes", bytes_q.size(), 2);
    check("one_word_bytes", {16'd0, bytes_q[0], bytes_q[1]}, 32'h00ff);
    check("one_word_reads", rd_q.size(), 1);
    check("one_word_addr", 32'(rd_q[0]), 0);
    check("one_word_done", done_cnt, 1);

    // Reset while waiting on the low byte of word 3.
    clear_obs();
    kick(5);
    begin
      int n = 0;
      while (bytes_q.size() < 8 && n < 500) begin cyc(); n++; end
      check("abort_reach_word3", 32'(n >= 500), 0);
    end
    cyc(2);
    RESET = 1;
    cyc();
    check("abort_outs", outs(), 0);
    RESET = 0;
    cyc(20);
    check("abort_no_done", done_cnt, 0);
    check("abort_nbytes", bytes_q.size(), 8);
    clear_obs();
    kick(0);
    wait_done("restart", 100);
    check("restart_addr", 32'(rd_q[0]), 0);
    check("restart_bytes", {16'd0, bytes_q[0], bytes_q[1]}, 32'h00ff);

    // START while busy and spurious TX_DONE during READ/CAPT are ignored.
    clear_obs();
    spur_en = 1;
    kick(2);
    cyc(4);
    kick(0);
    wait_done("ignore", 300);
    spur_en = 0;
    check("ignore_nbytes", bytes_q.size(), 6);
    bad = 0;
    for (int i = 0; i < 6 && i < bytes_q.size(); i++)
      if (bytes_q[i] !== ((i % 2) ? mem[i/2][7:0] : mem[i/2][15:8])) bad++;
    check("ignore_bytes", bad, 0);
    check("ignore_done", done_cnt, 1);

    // Full memory dump with no wrap back to address 0.
    for (int i = 0; i < 2048; i++) mem[i] = 16'(i * 16'h0105 + 16'h33);
    tx_lat = 1;
    clear_obs();
    kick(11'd2047);
    wait_done("full", 60000);
    check("full_nbytes", bytes_q.size(), 4096);
    check("full_last_addr", 32'(rd_q[rd_q.size()-1]), 2047);
    check("full_nreads", rd_q.size(), 2048);
    zero_rd = 0;
    foreach (rd_q[i]) if (rd_q[i] == 0) zero_rd++;
    check("full_zero_reads", zero_rd, 1);
    bad = 0;
    for (int i = 0; i < bytes_q.size() && i < 4096; i++)
      if (bytes_q[i] !== ((i % 2) ? mem[i/2][7:0] : mem[i/2][15:8])) bad++;
    check("full_bytes", bad, 0);
    check("full_done", done_cnt, 1);
    check("full_busy", 32'(BUSY), 0);
    check("never_write", wr_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
